dram_write_serializer: RTL and testbench
========================================

Name: dram_write_serializer

Overview:
- Opposite end of the scratchpad DRAM fill path: the fill path packs 64-bit DRAM beats into one SRAM row write; this block takes one SRAM row read response (512 b = 32 × 16-bit elements) and emits it as up to 8 sequential 64-bit DRAM write beats.
- Sits between the scratchpad SRAM read port and the DRAM write bus in the scratchpad backend.
- Tags each beat with the request's DRAM id and byte address, and flags the last beat.

Parameters:
- DRAM_BUS_WIDTH, 64, DRAM write data width per beat (bits).
- ROW_WIDTH, 512, SRAM row width (bits); ROW_WIDTH/DRAM_BUS_WIDTH = 8 beats max.
- ID_WIDTH, 8, DRAM transaction id width.
- ADDR_WIDTH, 32, DRAM byte address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- sram_res_valid  in  1  SRAM row read data valid.
- sram_res_ready  out  1  serializer can accept a row.
- sram_rddata  in  ROW_WIDTH  row data; beat k = bits [64k+63:64k].
- num_request  in  3  beats to send minus 1 (0 → 1 beat, 7 → 8 beats).
- dram_id  in  ID_WIDTH  id for the transaction.
- dram_base_addr  in  ADDR_WIDTH  byte address of beat 0.
- be_stall  in  1  backend stall.
- dram_wr_valid  out  1  beat valid.
- dram_wr_ready  in  1  DRAM accepts beat.
- dram_wr_data  out  DRAM_BUS_WIDTH  beat data.
- dram_wr_addr  out  ADDR_WIDTH  beat byte address.
- dram_wr_id  out  ID_WIDTH  latched id.
- dram_wr_last  out  1  final beat of transaction.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after last beat handshake.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset: state=IDLE; beat_cnt=0; all latched registers =0; dram_wr_valid=0, dram_wr_last=0, done=0, busy=0; sram_res_ready=0 during the reset cycle.
- FSM states: IDLE, SEND.
- IDLE:
  - sram_res_ready = !be_stall.
  - On sram_res_valid && sram_res_ready: latch row, num_request, dram_id, dram_base_addr; set beat_cnt=0; go to SEND next cycle.
- SEND:
  - dram_wr_valid = !be_stall.
  - dram_wr_data = latched row beat[beat_cnt].
  - dram_wr_addr = base + (beat_cnt << 3), modulo 2^ADDR_WIDTH (wraps silently).
  - dram_wr_last = (beat_cnt == num_latched).
  - sram_res_ready = 0.
- Handshake: a beat transfers only when dram_wr_valid && dram_wr_ready. On transfer, beat_cnt++. If dram_wr_last is high, go to IDLE and set done=1 for the next cycle.
- Stall handling:
  - be_stall high: valid drops and data/addr hold. The DRAM side must not see a transfer in a cycle where valid is low.
  - be_stall rising while valid&&!ready: valid drops. Permitted, because the bus samples only on handshake.
- Latency: first beat valid 1 cycle after row acceptance. Minimum transaction = 1 + (num_request+1) cycles. done coincides with the first IDLE cycle, in which a new row may be accepted (back-to-back supported).
- Registered outputs: sram_rddata/num_request changing while in SEND have no effect.
- beat_cnt is 3 bits. It never wraps, because the transition to IDLE occurs at beat_cnt==num_latched ≤ 7.
- rst mid-transaction: aborts immediately. No last beat and no done are issued. Outputs return to reset values next edge.

Optional Feature:
- Macro: DWS_STALL_CNT_EN.
- Defined: adds output stall_cycles [31:0]. It increments in every cycle where state==SEND && (be_stall || (dram_wr_valid && !dram_wr_ready)), saturates at 0xFFFFFFFF, and is cleared only by rst.
- Undefined: port absent, no counter logic.

Decomposition:
- scpad_pkg receives:
  - DRAM_BUS_WIDTH and DWS_MAX_BEATS=8 constants.
  - typedef dram_beat_idx_t (logic [2:0]).
  - typedef dram_write_req_t {valid, id, addr, data, last}; the DRAM-side outputs may be driven from it.
- No sub-module is needed. The FSM, beat counter, and 8:1 beat mux are all inline.

Test Plan:
- Full row, dram_wr_ready=1: num_request=7, base=0x1000, id=0x2A, row beat k = 0x1111_1111_1111_1111*k → 8 consecutive beats with addr 0x1000..0x1038 step 8, data beat k, id 0x2A, last only on beat 7, done 1 cycle after.
- Single beat: num_request=0, base=0x40 → one beat at addr 0x40, last=1, busy for 1 cycle, done pulse.
- Backpressure: num_request=3, dram_wr_ready low on cycles 2 and 4 → data/addr held stable while not ready, exactly 4 transfers, no duplicate or skipped beat.
- be_stall: be_stall high for 3 cycles mid-SEND → valid=0 for those cycles, resume at same beat_cnt; be_stall high in IDLE → sram_res_ready=0 and no acceptance.
- Back-to-back: second row valid during done cycle → accepted that cycle, first beat of second row next cycle. Address wrap: base=0xFFFF_FFF8, 2 beats → addresses 0xFFFF_FFF8 and 0x0.
- Reset mid-SEND after beat 2 of 8 → next cycle valid=0, busy=0, done never pulses. With DWS_STALL_CNT_EN, stall_cycles=0 after reset.

Source files
------------

// File: rtl/scpad_pkg.sv
// scpad_pkg: shared constants and types for the scratchpad backend DRAM path.
//   DRAM_BUS_WIDTH   : width of one DRAM write beat in bits.
//   DWS_MAX_BEATS    : beats per SRAM row (512 b row / 64 b beat).
//   dram_beat_idx_t  : index of a beat within a row.
//   dram_write_req_t : one DRAM write beat as seen on the bus.
//   dws_state_t      : serializer FSM states.
package scpad_pkg;

  localparam int DRAM_BUS_WIDTH = 64;
  localparam int DWS_MAX_BEATS  = 8;
  localparam int DWS_ID_WIDTH   = 8;
  localparam int DWS_ADDR_WIDTH = 32;

  typedef logic [2:0] dram_beat_idx_t;

  typedef struct packed {
    logic                      valid;
    logic [DWS_ID_WIDTH-1:0]   id;
    logic [DWS_ADDR_WIDTH-1:0] addr;
    logic [DRAM_BUS_WIDTH-1:0] data;
    logic                      last;
  } dram_write_req_t;

  typedef enum logic {
    DWS_IDLE = 1'b0,
    DWS_SEND = 1'b1
  } dws_state_t;

endpackage

// File: rtl/dram_write_serializer.sv
// dram_write_serializer: takes one SRAM row read response and emits it as
// up to DWS_MAX_BEATS sequential DRAM write beats, tagged with id, byte
// address (base + 8*beat) and a last flag.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   sram_res_valid/ready     row handshake (ready only when IDLE and not stalled)
//   sram_rddata              row data, beat k in bits [64k+63:64k]
//   num_request              beats to send minus one
//   dram_id, dram_base_addr  transaction id and byte address of beat 0
//   be_stall                 backend stall, suppresses both handshakes
//   dram_wr_*                DRAM write beat bus (valid/ready handshake)
//   busy                     transaction in progress
//   done                     one-cycle pulse after the last beat transfers
//   stall_cycles             (only with DWS_STALL_CNT_EN) saturating count of
//                            SEND cycles lost to stall or backpressure
//
// Optional feature macro: DWS_STALL_CNT_EN.
module dram_write_serializer #(
  parameter int DRAM_BUS_WIDTH = 64,
  parameter int ROW_WIDTH      = 512,
  parameter int ID_WIDTH       = 8,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sram_res_valid,
  output logic                      sram_res_ready,
  input  logic [ROW_WIDTH-1:0]      sram_rddata,
  input  logic [2:0]                num_request,
  input  logic [ID_WIDTH-1:0]       dram_id,
  input  logic [ADDR_WIDTH-1:0]     dram_base_addr,
  input  logic                      be_stall,
  output logic                      dram_wr_valid,
  input  logic                      dram_wr_ready,
  output logic [DRAM_BUS_WIDTH-1:0] dram_wr_data,
  output logic [ADDR_WIDTH-1:0]     dram_wr_addr,
  output logic [ID_WIDTH-1:0]       dram_wr_id,
  output logic                      dram_wr_last,
  output logic                      busy,
`ifdef DWS_STALL_CNT_EN
  output logic [31:0]               stall_cycles,
`endif
  output logic                      done
);
  import scpad_pkg::*;

  localparam int NUM_BEATS = ROW_WIDTH / DRAM_BUS_WIDTH;

  dws_state_t                r_state;
  dws_state_t                w_state_next;
  dram_beat_idx_t            r_beat_cnt;
  logic [2:0]                r_num;
  logic [ROW_WIDTH-1:0]      r_row;
  logic [ID_WIDTH-1:0]       r_id;
  logic [ADDR_WIDTH-1:0]     r_base;
  logic                      r_done;

  logic                      w_ready;
  logic                      w_valid;
  logic                      w_last;
  logic                      w_xfer;
  logic                      w_accept;
  logic [ADDR_WIDTH-1:0]     w_offset;
  logic [DRAM_BUS_WIDTH-1:0] w_beats [NUM_BEATS];

  // Split the latched row into beats for the beat mux.
  for (genvar gi = 0; gi < NUM_BEATS; gi++) begin : g_beat
    assign w_beats[gi] = r_row[gi*DRAM_BUS_WIDTH +: DRAM_BUS_WIDTH];
  end

  // Each beat advances the byte address by 8; the sum wraps at 2^ADDR_WIDTH.
  assign w_offset = {{(ADDR_WIDTH-6){1'b0}}, r_beat_cnt, 3'b000};

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_valid      = 1'b0;
    w_last       = 1'b0;
    w_xfer       = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      DWS_IDLE: begin
        w_ready  = !be_stall;
        w_accept = sram_res_valid && w_ready;
        if (w_accept) w_state_next = DWS_SEND;
      end
      DWS_SEND: begin
        w_valid = !be_stall;
        w_last  = (r_beat_cnt == r_num);
        w_xfer  = w_valid && dram_wr_ready;
        if (w_xfer && w_last) w_state_next = DWS_IDLE;
      end
      default: w_state_next = DWS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= DWS_IDLE;
      r_beat_cnt <= '0;
      r_num      <= '0;
      r_row      <= '0;
      r_id       <= '0;
      r_base     <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_xfer && w_last;
      if (w_accept) begin
        r_row      <= sram_rddata;
        r_num      <= num_request;
        r_id       <= dram_id;
        r_base     <= dram_base_addr;
        r_beat_cnt <= '0;
      end else if (w_xfer) begin
        r_beat_cnt <= r_beat_cnt + 3'd1;
      end
    end
  end

  // Handshake qualifiers are masked during reset so an aborted transaction
  // can never complete a transfer in the reset cycle.
  assign sram_res_ready = w_ready && !rst;
  assign dram_wr_valid  = w_valid && !rst;
  assign dram_wr_last   = w_last && !rst;
  assign dram_wr_data   = w_beats[r_beat_cnt];
  assign dram_wr_addr   = r_base + w_offset;
  assign dram_wr_id     = r_id;
  assign busy           = (r_state == DWS_SEND);
  assign done           = r_done;

`ifdef DWS_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if ((r_state == DWS_SEND) && (be_stall || (w_valid && !dram_wr_ready))
                 && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_dram_write_serializer.sv
module tb_dram_write_serializer;
  import scpad_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         sram_res_valid;
  logic         sram_res_ready;
  logic [511:0] sram_rddata;
  logic [2:0]   num_request;
  logic [7:0]   dram_id;
  logic [31:0]  dram_base_addr;
  logic         be_stall;
  logic         dram_wr_valid;
  logic         dram_wr_ready;
  logic [63:0]  dram_wr_data;
  logic [31:0]  dram_wr_addr;
  logic [7:0]   dram_wr_id;
  logic         dram_wr_last;
  logic         busy;
  logic         done;
`ifdef DWS_STALL_CNT_EN
  logic [31:0]  stall_cycles;
`endif

  always #5 clk = ~clk;

  dram_write_serializer dut (
    .clk            (clk),
    .rst            (rst),
    .sram_res_valid (sram_res_valid),
    .sram_res_ready (sram_res_ready),
    .sram_rddata    (sram_rddata),
    .num_request    (num_request),
    .dram_id        (dram_id),
    .dram_base_addr (dram_base_addr),
    .be_stall       (be_stall),
    .dram_wr_valid  (dram_wr_valid),
    .dram_wr_ready  (dram_wr_ready),
    .dram_wr_data   (dram_wr_data),
    .dram_wr_addr   (dram_wr_addr),
    .dram_wr_id     (dram_wr_id),
    .dram_wr_last   (dram_wr_last),
    .busy           (busy),
`ifdef DWS_STALL_CNT_EN
    .stall_cycles   (stall_cycles),
`endif
    .done           (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of beats still owed to the DRAM bus, plus the
  // externally visible busy/done/stall-count expectations.
  dram_write_req_t exp_q[$];
  logic            m_busy  = 1'b0;
  logic            m_done  = 1'b0;
  logic [31:0]     m_stall = 32'd0;
  int              n_beats = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the edge, check and advance the
  // model at the falling edge (inputs are stable for the coming edge).
  task automatic cyc(input logic rst_i, input logic v_i, input logic [511:0] row_i,
                     input logic [2:0] num_i, input logic [7:0] id_i,
                     input logic [31:0] base_i, input logic st_i, input logic rd_i);
    logic            exp_ready;
    logic            exp_valid;
    logic            done_next;
    dram_write_req_t e;
    @(posedge clk);
    #1;
    rst            = rst_i;
    sram_res_valid = v_i;
    sram_rddata    = row_i;
    num_request    = num_i;
    dram_id        = id_i;
    dram_base_addr = base_i;
    be_stall       = st_i;
    dram_wr_ready  = rd_i;
    @(negedge clk);
    if (rst_i) begin
      check_eq("ready_in_rst", {63'd0, sram_res_ready}, 64'd0);
      check_eq("valid_in_rst", {63'd0, dram_wr_valid}, 64'd0);
      exp_q.delete();
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_stall = 32'd0;
    end else begin
      exp_ready = !m_busy && !st_i;
      exp_valid = m_busy && !st_i;
      check_eq("sram_res_ready", {63'd0, sram_res_ready}, {63'd0, exp_ready});
      check_eq("dram_wr_valid", {63'd0, dram_wr_valid}, {63'd0, exp_valid});
      check_eq("busy", {63'd0, busy}, {63'd0, m_busy});
      check_eq("done", {63'd0, done}, {63'd0, m_done});
`ifdef DWS_STALL_CNT_EN
      check_eq("stall_cycles", {32'd0, stall_cycles}, {32'd0, m_stall});
      if (m_busy && (st_i || (exp_valid && !rd_i)) && m_stall != 32'hFFFF_FFFF)
        m_stall = m_stall + 32'd1;
`endif
      done_next = 1'b0;
      if (exp_valid) begin
        check_eq("beat_pending", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          check_eq("wr_data", dram_wr_data, e.data);
          check_eq("wr_addr", {32'd0, dram_wr_addr}, {32'd0, e.addr});
          check_eq("wr_id", {56'd0, dram_wr_id}, {56'd0, e.id});
          check_eq("wr_last", {63'd0, dram_wr_last}, {63'd0, e.last});
          if (rd_i) begin
            void'(exp_q.pop_front());
            n_beats++;
            $display("beat id=%02h addr=%08h data=%016h last=%0d", dram_wr_id,
                     dram_wr_addr, dram_wr_data, dram_wr_last);
            if (e.last) begin
              m_busy    = 1'b0;
              done_next = 1'b1;
            end
          end
        end
      end
      if (v_i && exp_ready) begin
        for (int k = 0; k <= int'(num_i); k++) begin
          e.valid = 1'b1;
          e.id    = id_i;
          e.addr  = base_i + 32'(8 * k);
          e.data  = row_i[64*k +: 64];
          e.last  = (k == int'(num_i));
          exp_q.push_back(e);
        end
        m_busy = 1'b1;
      end
      m_done = done_next;
    end
  endtask

  task automatic idle(input int n, input logic rd_i);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 3'd0, 8'd0, 32'd0, 1'b0, rd_i);
  endtask

  function automatic logic [511:0] rand_row();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  logic [511:0] row_a;
  logic [511:0] row_b;

  initial begin
    rst = 1'b1; sram_res_valid = 1'b0; sram_rddata = '0; num_request = '0;
    dram_id = '0; dram_base_addr = '0; be_stall = 1'b0; dram_wr_ready = 1'b0;
    cyc(1'b1, 1'b0, '0, 3'd0, 8'd0, 32'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, '0, 3'd0, 8'd0, 32'd0, 1'b0, 1'b0);
    idle(2, 1'b1);

    // Full row, always ready.
    for (int k = 0; k < 8; k++) row_a[64*k +: 64] = 64'h1111_1111_1111_1111 * 64'(k);
    cyc(1'b0, 1'b1, row_a, 3'd7, 8'h2A, 32'h1000, 1'b0, 1'b1);
    idle(10, 1'b1);

    // Single beat.
    row_b = rand_row();
    cyc(1'b0, 1'b1, row_b, 3'd0, 8'h11, 32'h40, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Backpressure: ready low on the 2nd and 4th SEND cycles; inputs
    // change during SEND and must be ignored.
    row_b = rand_row();
    cyc(1'b0, 1'b1, row_b, 3'd3, 8'h33, 32'h200, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, rand_row(), 3'd7, 8'h99, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, rand_row(), 3'd7, 8'h99, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, '0, 3'd0, 8'd0, 32'd0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, '0, 3'd0, 8'd0, 32'd0, 1'b0, 1'b0);
    idle(4, 1'b1);

    // be_stall for 3 cycles mid-SEND, then stall while IDLE with a row offered.
    row_b = rand_row();
    cyc(1'b0, 1'b1, row_b, 3'd7, 8'h44, 32'h800, 1'b0, 1'b1);
    idle(2, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 3'd0, 8'd0, 32'd0, 1'b1, 1'b1);
    idle(8, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, rand_row(), 3'd1, 8'h55, 32'h0, 1'b1, 1'b1);
    idle(1, 1'b1);

    // Back-to-back rows with the second offered continuously, then address wrap.
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, rand_row(), 3'd1, 8'(i), 32'h3000 + 32'(i * 64), 1'b0, 1'b1);
    idle(4, 1'b1);
    cyc(1'b0, 1'b1, rand_row(), 3'd1, 8'h77, 32'hFFFF_FFF8, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Reset after two beats of an eight-beat row: no last, no done.
    cyc(1'b0, 1'b1, rand_row(), 3'd7, 8'h66, 32'h5000, 1'b0, 1'b1);
    idle(2, 1'b1);
    cyc(1'b1, 1'b0, '0, 3'd0, 8'd0, 32'd0, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'b0, ($urandom_range(0, 1) == 1), rand_row(), 3'($urandom_range(0, 7)),
          8'($urandom), (i % 97 == 0) ? 32'hFFFF_FFE0 : $urandom,
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
    end
    idle(12, 1'b1);

    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
